// File: rtl/shift_rotate_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_sequencer_if
// Brief    : Request/response bundle for the shift/rotate sequencer.
//            The master issues a start with operands; the slave reports
//            busy, a one-cycle done pulse and the registered result.
// Revision : 1.0  initial release
// ============================================================================
interface shift_rotate_sequencer_if #(
    parameter int CNT_W = 3
);
    logic             start;
    logic [3:0]       A;
    logic [3:0]       B;
    logic [2:0]       op_sel;
    logic [CNT_W-1:0] count;
    logic [3:0]       result;
    logic             busy;
    logic             done;

    modport master (
        output start, A, B, op_sel, count,
        input  result, busy, done
    );

    modport slave (
        input  start, A, B, op_sel, count,
        output result, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/shift_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_sequencer
// Brief    : Multi-cycle 4-bit shifter/rotator. An accepted start latches an
//            operand, an operation and a step count; one single-bit shift or
//            rotate is applied per clock, then result is updated and done
//            pulses for one cycle.
// Revision : 1.0  initial release
// ============================================================================
module shift_rotate_sequencer #(
    parameter int CNT_W = 3
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    shift_rotate_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_zero = '0;

    logic [1:0]       r_state;
    logic [3:0]       r_work;
    logic [CNT_W-1:0] r_remaining;
    logic [2:0]       r_op;
    logic [3:0]       r_result;

    logic [3:0]       w_operand;
    logic [3:0]       w_step;

    // One single-bit step: op[2] selects rotate over shift, op[0] selects left.
    function automatic logic [3:0] step_once(input logic [3:0] w, input logic [2:0] op);
        logic [3:0] r;
        case ({op[2], op[0]})
            2'b00:   r = {1'b0, w[3:1]};     // SHR
            2'b01:   r = {w[2:0], 1'b0};     // SHL
            2'b10:   r = {w[0], w[3:1]};     // ROR
            default: r = {w[2:0], w[3]};     // ROL
        endcase
        return r;
    endfunction

    // Operand choice follows op_sel[1]; the step uses the latched operation.
    always_comb begin
        w_operand = bus.op_sel[1] ? bus.B : bus.A;
        w_step    = step_once(r_work, r_op);
    end

    // Sequencer FSM: accept in IDLE, step in RUN, single-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_work      <= 4'b0000;
            r_remaining <= c_zero;
            r_op        <= 3'b000;
            r_result    <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_work      <= w_operand;
                        r_remaining <= bus.count;
                        r_op        <= bus.op_sel;
                        if (bus.count == c_zero) begin
                            // Zero steps: the operand itself is the answer.
                            r_result <= w_operand;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_work      <= w_step;
                    r_remaining <= r_remaining - c_one;
                    if (r_remaining == c_one) begin
                        r_result <= w_step;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        bus.busy   = (r_state != S_IDLE);
        bus.done   = (r_state == S_DONE);
        bus.result = r_result;
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_rotate_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rotate_sequencer
// Brief    : Directed self-checking bench for shift_rotate_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_rotate_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    shift_rotate_sequencer_if #(.CNT_W(3)) bus ();

    shift_rotate_sequencer #(.CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, scramble the inputs after acceptance, and check
    // latency, busy coverage, the result and the return to idle.
    task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] exp);
        int   lat;
        logic busy_ok;
        bus.A = a; bus.B = b; bus.op_sel = op; bus.count = cnt; bus.start = 1'b1;
        tick();
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b; bus.op_sel = ~op; bus.count = ~cnt;
        lat = 1;
        busy_ok = 1'b1;
        while (!bus.done && lat < 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, int'(cnt) + 1);
        check({tag, " busy_run"}, busy_ok, 1'b1);
        check({tag, " busy_done"}, bus.busy, 1'b1);
        check({tag, " result"}, bus.result, exp);
        tick();
        check({tag, " done_low"}, bus.done, 1'b0);
        check({tag, " idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        logic [11:0] done_seen;
        logic [11:0] busy_seen;
        int          guard;

        bus.start = 1'b0; bus.A = 4'h0; bus.B = 4'h0; bus.op_sel = 3'd0; bus.count = 3'd0;
        rst = 1'b1;
        tick(); tick(); tick();
        check("reset result", bus.result, 4'b0000);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        rst = 1'b0;
        tick();

        run_op("shr_a_2",  4'b1011, 4'b0000, 3'd0, 3'd2, 4'b0010);
        run_op("rol_b_3",  4'b0000, 4'b1001, 3'd7, 3'd3, 4'b1100);
        run_op("ror_a_4",  4'b1011, 4'b0000, 3'd4, 3'd4, 4'b1011);
        run_op("shl_b_0",  4'b0000, 4'b0110, 3'd3, 3'd0, 4'b0110);
        run_op("shl_a_7",  4'b1111, 4'b0000, 3'd1, 3'd7, 4'b0000);
        run_op("ror_a_5",  4'b1011, 4'b0000, 3'd4, 3'd5, 4'b1101);
        run_op("shr_b_4",  4'b0000, 4'b1111, 3'd2, 3'd4, 4'b0000);
        run_op("rol_a_1",  4'b1000, 4'b0000, 3'd5, 3'd1, 4'b0001);
        run_op("ror_b_2",  4'b0000, 4'b0110, 3'd6, 3'd2, 4'b1001);

        // Result must hold while idle, even with inputs wiggling.
        bus.A = 4'hF; bus.B = 4'hF; bus.op_sel = 3'd7; bus.count = 3'd1;
        tick(); tick(); tick();
        check("hold result", bus.result, 4'b1001);

        // start held high: one done per operation, period count+2.
        bus.A = 4'b0001; bus.B = 4'b0000; bus.op_sel = 3'd1; bus.count = 3'd3; bus.start = 1'b1;
        done_seen = '0;
        busy_seen = '0;
        for (int k = 0; k < 12; k++) begin
            tick();
            done_seen[k] = bus.done;
            busy_seen[k] = bus.busy;
        end
        check("held done pattern", done_seen, 12'h108);
        check("held busy pattern", busy_seen, 12'hDEF);
        bus.start = 1'b0;
        guard = 0;
        while (bus.busy && guard < 20) begin
            tick();
            guard++;
        end
        check("held drain", bus.busy, 1'b0);
        check("held result", bus.result, 4'b1000);

        // Reset in the second RUN cycle aborts without a done pulse.
        bus.A = 4'b1111; bus.op_sel = 3'd0; bus.count = 3'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort run1 done", bus.done, 1'b0);
        tick();
        check("abort run2 busy", bus.busy, 1'b1);
        rst = 1'b1;
        tick();
        check("abort done", bus.done, 1'b0);
        check("abort busy", bus.busy, 1'b0);
        check("abort result", bus.result, 4'b0000);
        rst = 1'b0;
        tick();
        check("abort no late done", bus.done, 1'b0);
        run_op("after_rst", 4'b0110, 4'b0000, 3'd5, 3'd2, 4'b1001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_rotate_sequencer.md
SHIFT_ROTATE_SEQUENCER -- requirements
Module: shift_rotate_sequencer

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 3, width of the step-count input (maximum 2^CNT_W-1 steps).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  request pulse, sampled only in IDLE.
REQ-005 A  input  4  operand A, sampled on the accepted start.
REQ-006 B  input  4  operand B, sampled on the accepted start.
REQ-007 op_sel  input  3  operation code, sampled on the accepted start.
REQ-008 count  input  CNT_W  number of single-bit steps, sampled on the accepted start.
REQ-009 result  output  4  registered final value.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 done  output  1  one-cycle completion pulse.

Function
REQ-012 op_sel encoding SHALL be: 0 SHR A, 1 SHL A, 2 SHR B, 3 SHL B, 4 ROR A, 5 ROL A, 6 ROR B, 7 ROL B.
REQ-013 Operand SHALL be B when op_sel[1]=1, else A.
REQ-014 One step SHALL be:
- SHR: {0,w[3:1]}
- SHL: {w[2:0],0}
- ROR: {w[0],w[3:1]}
- ROL: {w[2:0],w[3]}
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE, start=1: the block SHALL load the work register with the selected operand, load remaining with count, and latch op_sel.
- count=0: next state DONE.
- count>0: next state RUN.
REQ-017 IDLE, start=0: the block SHALL hold all state and outputs.
REQ-018 RUN: each cycle, the block SHALL apply one step to the work register and decrement remaining by 1.
- remaining=1 at that edge: next state DONE.
REQ-019 On entering DONE, result SHALL be written with the final work value.
REQ-020 DONE: done=1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-021 Latency: start accepted in cycle T SHALL give done=1 in cycle T+count+1; busy SHALL be high in cycles T+1 through T+count+1.
REQ-022 start while busy=1 (RUN or DONE) SHALL be ignored, and SHALL not be queued.
REQ-023 Changes on A, B, op_sel and count after acceptance SHALL not affect the operation in progress.
REQ-024 result SHALL hold its value between completions.
REQ-025 Rotates SHALL be modulo 4: count=4 returns the operand; counts 5..7 equal counts 1..3.
REQ-026 Shifts with count>=4 SHALL yield 4'b0000.
REQ-027 Back-to-back operation: start high in the cycle after done SHALL be accepted, giving a minimum of count+2 cycles per operation.

Reset
REQ-028 While rst=1 at a clock edge, the block SHALL set state=IDLE, result=4'b0000, busy=0, done=0, work register=0, remaining=0 and latched op_sel=0.
REQ-029 rst SHALL take priority over start and over every FSM transition.
REQ-030 Reset during RUN or DONE SHALL abort the operation with no done pulse, and result SHALL read 0.
REQ-031 The first start after rst deasserts SHALL be accepted normally.

Verification
REQ-032 SHR A: A=4'b1011, op_sel=0, count=2, start in T -> done in T+3, result=4'b0010, busy high T+1..T+3.
REQ-033 ROL B: B=4'b1001, op_sel=7, count=3 -> result=4'b1100; ROR A: A=4'b1011, op_sel=4, count=4 -> result=4'b1011.
REQ-034 count=0: op_sel=3, B=4'b0110 -> done in T+1, result=4'b0110.
REQ-035 SHL A: A=4'b1111, op_sel=1, count=7 -> result=4'b0000, done in T+8.
REQ-036 start=1 held in every cycle of a count=3 operation -> exactly one done pulse per operation; a second operation is accepted only in the cycle after done.
REQ-037 rst=1 in the second RUN cycle -> no done pulse, result=0, busy=0 next cycle; a subsequent start completes correctly.
